// File: rtl/trig_counter_bank_if.sv
// Readout handshake bundle for trig_counter_bank.
// The master requests a channel and consumes words; the slave (the counter bank) streams them.
interface trig_counter_bank_if #(
    parameter int CH_W = 1
);
    logic            rd_req;
    logic [CH_W-1:0] rd_ch;
    logic            rd_ready;
    logic [15:0]     rd_data;
    logic            rd_valid;
    logic            rd_last;
    logic            rd_busy;
    logic            rd_err;

    modport master (
        output rd_req, rd_ch, rd_ready,
        input  rd_data, rd_valid, rd_last, rd_busy, rd_err
    );

    modport slave (
        input  rd_req, rd_ch, rd_ready,
        output rd_data, rd_valid, rd_last, rd_busy, rd_err
    );
endinterface

// File: rtl/trig_counter_bank.sv
// N_CH trigger-driven up/down/load counters with sticky flags, atomic snapshot and a 16-bit word readout.
// Define TRIG_COUNTER_BANK_SATURATE_EN to make counters saturate instead of wrapping.
module trig_counter_bank #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 32,
    parameter int CH_W  = 1
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       trig_clr,
    input  logic [N_CH-1:0]       trig_load,
    input  logic [N_CH-1:0]       trig_up,
    input  logic [N_CH-1:0]       trig_down,
    input  logic [N_CH*WIDTH-1:0] load_value,
    input  logic                  flag_clr,
    input  logic                  snap_req,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       ovf,
    output logic [N_CH-1:0]       udf,
    trig_counter_bank_if.slave    rd
);
    localparam int WORDS = (WIDTH + 15) / 16;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PAD_W = WORDS * 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {IDLE, SEND} state_e;

    logic [WIDTH-1:0] cnt_q    [N_CH];
    logic [WIDTH-1:0] cnt_d    [N_CH];
    logic [WIDTH-1:0] shadow_q [N_CH];
    logic [WIDTH-1:0] shadow_d [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d, udf_q, udf_d;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             err_q, err_d;

    logic             busy, ch_ok, snap_ok;
    logic [PAD_W-1:0] sel_pad;
    logic [15:0]      word;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i] & ~flag_clr;
            udf_d[i] = udf_q[i] & ~flag_clr;
            if (trig_clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
                udf_d[i] = 1'b0;
            end else if (trig_load[i]) begin
                cnt_d[i] = load_value[i*WIDTH +: WIDTH];
            end else if (trig_up[i] && !trig_down[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
`ifdef TRIG_COUNTER_BANK_SATURATE_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end else if (trig_down[i] && !trig_up[i]) begin
                if (cnt_q[i] == '0) begin
                    udf_d[i] = 1'b1;
`ifdef TRIG_COUNTER_BANK_SATURATE_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = '1;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end
        end
    end

    assign busy    = (state_q == SEND);
    assign snap_ok = snap_req && !busy;

    always_comb begin
        ch_ok = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd.rd_ch == i[CH_W-1:0]) ch_ok = 1'b1;
        end
    end

    // Shadows capture the pre-update counts, so a same-cycle trigger is excluded.
    always_comb begin
        shadow_d = shadow_q;
        if (snap_ok) shadow_d = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd.rd_req) begin
                    if (ch_ok) begin
                        state_d = SEND;
                        idx_d   = '0;
                        ch_d    = rd.rd_ch;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (rd.rd_req || snap_req) err_d = 1'b1;
                if (rd.rd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_pad = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == i[CH_W-1:0]) sel_pad[WIDTH-1:0] = shadow_q[i];
        end
        word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == w[IDX_W-1:0]) word = sel_pad[w*16 +: 16];
        end
    end

    // Readout outputs decode the state register, so they fall as soon as reset asserts.
    assign rd.rd_valid = busy;
    assign rd.rd_busy  = busy;
    assign rd.rd_last  = busy && (idx_q == LAST_IDX);
    assign rd.rd_data  = busy ? word : 16'h0000;
    assign rd.rd_err   = err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign count[g*WIDTH +: WIDTH] = cnt_q[g];
    end
    assign ovf = ovf_q;
    assign udf = udf_q;

    // NOTE: sequential state uses non-blocking assignments only; the shadow array is reset too, since its contents are observable.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '{default: '0};
            shadow_q <= '{default: '0};
            ovf_q    <= '0;
            udf_q    <= '0;
            state_q  <= IDLE;
            idx_q    <= '0;
            ch_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            ch_q     <= ch_d;
            err_q    <= err_d;
        end
    end
endmodule
